// File: rtl/ff_pkg.sv
// Shared constants, FSM encoding and float helpers for the feedforward datapath.
package ff_pkg;

    localparam logic [31:0] FP_ZERO     = 32'h00000000;
    localparam logic [31:0] FP_ONE      = 32'h3f800000;
    localparam int unsigned FP_SIGN_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    // Strictly positive: sign clear and a non-zero magnitude (so +0 and -0 are excluded).
    function automatic logic fp_is_pos(input logic [31:0] x);
        return (x[FP_SIGN_BIT] == 1'b0) && (x[FP_SIGN_BIT-1:0] != '0);
    endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of a level input.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/act_collector.sv
// Collects one activation per done edge into a layer buffer and hands the full
// layer to the next stage through a registered read port and valid/ack handshake.
module act_collector
    import ff_pkg::*;
#(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] act_data,
    input  logic              act_done,
    output logic              act_rdy,
    output logic [ADDR_W-1:0] neuron_idx,
    output logic              layer_valid,
    input  logic              layer_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   pos_count,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic              strobe;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] buffer [N_NEURONS];

    edge_det u_done_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (act_done),
        .rise (strobe)
    );

    // A strobe landing together with the release of a full layer starts the next one.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = index;
        if (strobe) begin
            if (state == ST_COLLECT) begin
                wr_en = 1'b1;
            end else if (state == ST_FULL && layer_ack) begin
                wr_en  = 1'b1;
                wr_idx = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            index       <= '0;
            pos_count   <= '0;
            act_rdy     <= 1'b0;
            layer_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (strobe) overflow <= 1'b1;
                    if (start) begin
                        state     <= ST_COLLECT;
                        index     <= '0;
                        pos_count <= '0;
                        act_rdy   <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (strobe) begin
                        if (fp_is_pos(act_data)) pos_count <= pos_count + (ADDR_W+1)'(1);
                        if (index == LAST_IDX) begin
                            state       <= ST_FULL;
                            index       <= '0;
                            act_rdy     <= 1'b0;
                            layer_valid <= 1'b1;
                        end else begin
                            index <= index + ADDR_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (layer_ack) begin
                        state       <= ST_COLLECT;
                        act_rdy     <= 1'b1;
                        layer_valid <= 1'b0;
                        if (strobe) begin
                            index     <= ADDR_W'(1);
                            pos_count <= {{ADDR_W{1'b0}}, fp_is_pos(act_data)};
                        end else begin
                            index     <= '0;
                            pos_count <= '0;
                        end
                    end else if (strobe) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_NEURONS); i++) buffer[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) buffer[wr_idx] <= act_data;
            rd_data <= (int'(rd_addr) < int'(N_NEURONS)) ? buffer[rd_addr] : '0;
        end
    end

    assign neuron_idx = index;

endmodule

// File: tb/tb_act_collector.sv
// Randomized and directed bench for act_collector against a queue-level layer model.
module tb_act_collector;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] act_data;
    logic          act_done;
    logic          act_rdy;
    logic [AW-1:0] neuron_idx;
    logic          layer_valid;
    logic          layer_ack;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW:0]   pos_count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    act_collector #(
        .N_NEURONS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .act_data    (act_data),
        .act_done    (act_done),
        .act_rdy     (act_rdy),
        .neuron_idx  (neuron_idx),
        .layer_valid (layer_valid),
        .layer_ack   (layer_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pos_count   (pos_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Model: the current layer is a queue of captured values; a held layer is a full array.
    logic [31:0] m_layer [$];
    logic [31:0] m_buf [N];
    bit          m_armed, m_full, m_ovf, m_done_prev;
    logic [31:0] m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_positive(input logic [31:0] v);
        logic sign;
        sign = v[31];
        return !sign && (v != 32'h0);
    endfunction

    function automatic int m_pos();
        int c = 0;
        if (m_full) begin
            for (int i = 0; i < N; i++) if (is_positive(m_buf[i])) c++;
        end else if (m_armed) begin
            foreach (m_layer[i]) if (is_positive(m_layer[i])) c++;
        end
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_buf[i] = 32'h0;
        m_layer.delete();
        m_armed = 0; m_full = 0; m_ovf = 0; m_done_prev = 0; m_rd = 32'h0;
    endtask

    task automatic m_capture(input logic [31:0] v);
        m_buf[m_layer.size()] = v;
        m_layer.push_back(v);
        if (m_layer.size() == N) begin
            m_armed = 0;
            m_full  = 1;
            m_layer.delete();
        end
    endtask

    task automatic m_step();
        bit strobe;
        strobe = act_done && !m_done_prev;
        m_rd   = (int'(rd_addr) < N) ? m_buf[rd_addr] : 32'h0;
        if (m_armed) begin
            if (strobe) m_capture(act_data);
        end else if (m_full) begin
            if (layer_ack) begin
                m_full  = 0;
                m_armed = 1;
                if (strobe) m_capture(act_data);
            end else if (strobe) begin
                m_ovf = 1;
            end
        end else begin
            if (strobe) m_ovf = 1;
            if (start) begin
                m_armed = 1;
                m_layer.delete();
            end
        end
        m_done_prev = act_done;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_rdy"}, 32'(act_rdy), 32'(m_armed));
        check({tag, "_idx"}, 32'(neuron_idx), m_armed ? 32'(m_layer.size()) : 32'h0);
        check({tag, "_valid"}, 32'(layer_valid), 32'(m_full));
        check({tag, "_pos"}, 32'(pos_count), 32'(m_pos()));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_rd"}, rd_data, m_rd);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic feed(input logic [31:0] v, input int hold, input string tag);
        act_data = v;
        act_done = 1'b1;
        repeat (hold) cycle(tag);
        act_done = 1'b0;
        cycle(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(act_rdy), 32'h0);
        check({tag, "_idx"}, 32'(neuron_idx), 32'h0);
        check({tag, "_valid"}, 32'(layer_valid), 32'h0);
        check({tag, "_pos"}, 32'(pos_count), 32'h0);
        check({tag, "_ovf"}, 32'(overflow), 32'h0);
        check({tag, "_rd"}, rd_data, 32'h0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_act();
        logic [31:0] v;
        v = $urandom();
        if ($urandom_range(0, 7) == 0) v = (v[0]) ? 32'h80000000 : 32'h00000000;
        return v;
    endfunction

    logic [31:0] layer2 [N];

    initial begin
        rst = 1'b1; start = 1'b0; act_data = '0; act_done = 1'b0;
        layer_ack = 1'b0; rd_addr = '0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // 1: arm and read an empty buffer
        start = 1'b1;
        cycle("t1_start");
        start = 1'b0;
        check("t1_rdy", 32'(act_rdy), 32'h1);
        for (int a = 0; a < N; a++) begin
            rd_addr = AW'(a);
            cycle("t1_rd");
            check("t1_rd0", rd_data, 32'h0);
        end

        // 2: four activations, each done held three cycles
        layer2 = '{32'h40400000, 32'hbf800000, 32'h00000000, 32'h3f800000};
        for (int i = 0; i < N; i++) feed(layer2[i], 3, "t2_feed");
        check("t2_valid", 32'(layer_valid), 32'h1);
        check("t2_pos", 32'(pos_count), 32'h2);
        for (int a = 0; a < N; a++) begin
            rd_addr = AW'(a);
            cycle("t2_rd");
            check("t2_rdval", rd_data, layer2[a]);
        end

        // 3: done held high across the transition into FULL, then a fresh edge
        layer_ack = 1'b1;
        cycle("t3_ack");
        layer_ack = 1'b0;
        for (int i = 0; i < N - 1; i++) feed(32'h40000000 + 32'(i), 2, "t3_feed");
        act_data = 32'h40a00000;
        act_done = 1'b1;
        repeat (6) cycle("t3_hold");
        check("t3_valid", 32'(layer_valid), 32'h1);
        check("t3_ovf0", 32'(overflow), 32'h0);
        act_done = 1'b0;
        cycle("t3_low");
        act_data = 32'hdeadbeef;
        act_done = 1'b1;
        cycle("t3_edge");
        act_done = 1'b0;
        rd_addr = 2'd0;
        cycle("t3_low2");
        check("t3_ovf1", 32'(overflow), 32'h1);
        check("t3_buf0", rd_data, 32'h40000000);

        // 4: strobe coincident with layer_ack
        act_data = 32'h41200000;
        act_done = 1'b1;
        layer_ack = 1'b1;
        cycle("t4_ack");
        layer_ack = 1'b0;
        act_done = 1'b0;
        check("t4_idx", 32'(neuron_idx), 32'h1);
        check("t4_pos", 32'(pos_count), 32'h1);
        check("t4_valid", 32'(layer_valid), 32'h0);
        cycle("t4_rd");
        check("t4_buf0", rd_data, 32'h41200000);

        // 5: negative zero is stored but not counted
        feed(32'h80000000, 1, "t5_feed");
        rd_addr = 2'd1;
        cycle("t5_rd");
        check("t5_buf1", rd_data, 32'h80000000);
        check("t5_pos", 32'(pos_count), 32'h1);

        // 6: asynchronous reset after two captures
        async_reset("t6_rst");
        start = 1'b1;
        cycle("t6_start");
        start = 1'b0;
        feed(32'h3f800000, 1, "t6_feed");
        check("t6_idx", 32'(neuron_idx), 32'h1);
        rd_addr = 2'd0;
        cycle("t6_rd0");
        check("t6_buf0", rd_data, 32'h3f800000);
        rd_addr = 2'd1;
        cycle("t6_rd1");
        check("t6_buf1", rd_data, 32'h0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 15) == 0);
            layer_ack = ($urandom_range(0, 5) == 0);
            rd_addr   = AW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 1) == 1) act_done = ~act_done;
            if (!act_done) act_data = rand_act();
            cycle("rnd");
            if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
